// File: rtl/sample_pack4.sv
// sample_pack4 -- packs 2-bit GPS front-end samples (sign, magnitude) into
// bytes of four samples, MSB-first, entirely in the sample clock domain.
// Completed bytes pass through a one-cycle staging register and then enter a
// 2-entry output FIFO drained through a valid/ready handshake. Bytes arriving
// at a full FIFO with no pop that cycle are dropped and counted.
//
// Ports:
//   clk            sample clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   sample_in[1:0] sample, bit 1 = sign, bit 0 = magnitude
//   sample_en      sample_in valid this cycle
//   sync           restart packing at slot 0, discarding any partial byte
//   byte_out[7:0]  head of output FIFO
//   byte_valid     FIFO non-empty
//   byte_ready     consumer takes byte_out when byte_valid is high
//   overflow       sticky drop flag
//   drop_count     saturating count of dropped bytes
//   clear_overflow clears overflow and drop_count (a same-cycle drop wins)
module sample_pack4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sample_in,
  input  logic       sample_en,
  input  logic       sync,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       overflow,
  output logic [7:0] drop_count,
  input  logic       clear_overflow
);

  // packer state: slot counter and the upper six bits of the byte in progress
  logic [1:0] slot_q, slot_d, slot_eff;
  logic [5:0] part_q, part_d, part_eff;
  // staging register: completed byte, pushed into the FIFO one edge later
  logic       stg_vld_q, stg_vld_d;
  logic [7:0] stg_q, stg_d;
  // 2-entry FIFO, entry 0 is the head and drives byte_out directly
  logic [7:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [7:0] dc_q, dc_d;
  logic       pop, drop;

  // A sync in the same cycle as sample_en makes that sample slot 0.
  always_comb begin
    slot_eff  = sync ? 2'd0 : slot_q;
    part_eff  = sync ? 6'd0 : part_q;
    slot_d    = slot_eff;
    part_d    = part_eff;
    stg_vld_d = 1'b0;
    stg_d     = stg_q;
    if (sample_en) begin
      slot_d = slot_eff + 2'd1;
      case (slot_eff)
        2'd0: part_d = {sample_in, 4'b0000};
        2'd1: part_d = {part_eff[5:4], sample_in, 2'b00};
        2'd2: part_d = {part_eff[5:2], sample_in};
        default: begin
          part_d    = 6'd0;
          stg_vld_d = 1'b1;
          stg_d     = {part_eff, sample_in};
        end
      endcase
    end
  end

  assign pop  = (cnt_q != 2'd0) && byte_ready;
  // a pop in the same cycle frees a slot, so a full FIFO only drops without one
  assign drop = stg_vld_q && (cnt_q == 2'd2) && !pop;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    if (pop) begin
      mem0_d = mem1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (stg_vld_q && !drop) begin
      if (cnt_d == 2'd0) mem0_d = stg_q;
      else               mem1_d = stg_q;
      cnt_d = cnt_d + 2'd1;
    end
  end

  // clear is applied first so a coincident drop leaves overflow=1, count=1
  always_comb begin
    ovf_d = ovf_q;
    dc_d  = dc_q;
    if (clear_overflow) begin
      ovf_d = 1'b0;
      dc_d  = 8'd0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (dc_d != 8'hFF) dc_d = dc_d + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q    <= 2'd0;
      part_q    <= 6'd0;
      stg_vld_q <= 1'b0;
      stg_q     <= 8'd0;
      mem0_q    <= 8'd0;
      mem1_q    <= 8'd0;
      cnt_q     <= 2'd0;
      ovf_q     <= 1'b0;
      dc_q      <= 8'd0;
    end else begin
      slot_q    <= slot_d;
      part_q    <= part_d;
      stg_vld_q <= stg_vld_d;
      stg_q     <= stg_d;
      mem0_q    <= mem0_d;
      mem1_q    <= mem1_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      dc_q      <= dc_d;
    end
  end

  assign byte_out   = mem0_q;
  assign byte_valid = (cnt_q != 2'd0);
  assign overflow   = ovf_q;
  assign drop_count = dc_q;

endmodule

// File: tb/tb_sample_pack4.sv
module tb_sample_pack4;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sample_in;
  logic       sample_en;
  logic       sync;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_overflow;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] expq[$];

  sample_pack4 dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_en(sample_en),
    .sync(sync), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .overflow(overflow), .drop_count(drop_count),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every accepted byte must match the next expected byte
  initial forever begin
    @(negedge clk);
    if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
      if (expq.size() == 0) begin
        ntests++;
        assert (0) else begin
          nfail++;
          $error("FAIL pop_unexpected: got byte %h expected no byte", byte_out);
        end
      end else begin
        chk("pop_data", byte_out, expq.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic samp(input logic [1:0] s, input logic syn);
    sample_in = s; sample_en = 1'b1; sync = syn;
    @(posedge clk); #1;
    sample_en = 1'b0; sync = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) samp(b[2*i +: 2], 1'b0);
  endtask

  initial begin
    reset = 1'b1; sample_in = 2'b00; sample_en = 1'b0; sync = 1'b0;
    byte_ready = 1'b0; clear_overflow = 1'b0;
    cyc(2);
    chk("rst_valid", {7'd0, byte_valid}, 8'd0);
    chk("rst_byte", byte_out, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    chk("rst_dc", drop_count, 8'd0);
    reset = 1'b0;
    cyc(1);

    // basic packing and latency
    byte_ready = 1'b1;
    expq.push_back(8'hE4);
    samp(2'b11, 0); samp(2'b10, 0); samp(2'b01, 0); samp(2'b00, 0);
    chk("lat_not_yet", {7'd0, byte_valid}, 8'd0);
    cyc(1);
    chk("lat_valid", {7'd0, byte_valid}, 8'd1);
    chk("lat_byte", byte_out, 8'hE4);
    cyc(1);
    chk("one_pulse", {7'd0, byte_valid}, 8'd0);
    chk("e4_ovf", {7'd0, overflow}, 8'd0);

    // gapped sample_en
    expq.push_back(8'h55); expq.push_back(8'h55);
    for (int i = 0; i < 8; i++) begin samp(2'b01, 0); cyc(1); end
    cyc(3);
    chk("gap_drained", 8'(expq.size()), 8'd0);

    // overflow with consumer stalled
    byte_ready = 1'b0;
    expq.push_back(8'h1B); expq.push_back(8'h2D);
    send_byte(8'h1B); send_byte(8'h2D); send_byte(8'h3C);
    cyc(1);
    chk("ovf_set", {7'd0, overflow}, 8'd1);
    chk("ovf_dc1", drop_count, 8'd1);
    chk("ovf_head", byte_out, 8'h1B);
    chk("ovf_valid", {7'd0, byte_valid}, 8'd1);
    byte_ready = 1'b1;
    cyc(3);
    chk("ovf_empty", {7'd0, byte_valid}, 8'd0);
    chk("ovf_drained", 8'(expq.size()), 8'd0);
    clear_overflow = 1'b1; cyc(1); clear_overflow = 1'b0;
    chk("clr_ovf", {7'd0, overflow}, 8'd0);
    chk("clr_dc", drop_count, 8'd0);

    // full FIFO, pop on the same edge the new byte is pushed: no drop
    byte_ready = 1'b0;
    expq.push_back(8'hA1); expq.push_back(8'hB2); expq.push_back(8'hC3);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    byte_ready = 1'b1;
    cyc(1);
    chk("full_pop_ovf", {7'd0, overflow}, 8'd0);
    chk("full_pop_dc", drop_count, 8'd0);
    chk("full_pop_head", byte_out, 8'hB2);
    cyc(4);
    chk("full_pop_drained", 8'(expq.size()), 8'd0);

    // sync coincident with a sample restarts the byte
    expq.push_back(8'h1B);
    samp(2'b11, 0); samp(2'b11, 0);
    samp(2'b00, 1); samp(2'b01, 0); samp(2'b10, 0); samp(2'b11, 0);
    cyc(3);
    chk("sync_drained", 8'(expq.size()), 8'd0);
    chk("sync_ovf", {7'd0, overflow}, 8'd0);

    // saturating drop count; these bytes are never consumed (reset below)
    byte_ready = 1'b0;
    for (int i = 0; i < 262; i++) send_byte(8'h00);
    cyc(1);
    chk("sat_dc", drop_count, 8'hFF);
    chk("sat_ovf", {7'd0, overflow}, 8'd1);
    send_byte(8'h00);
    clear_overflow = 1'b1; cyc(1); clear_overflow = 1'b0;
    chk("clr_drop_ovf", {7'd0, overflow}, 8'd1);
    chk("clr_drop_dc", drop_count, 8'd1);

    // asynchronous reset mid-byte with two buffered entries
    samp(2'b10, 0); samp(2'b01, 0);
    chk("pre_rst_valid", {7'd0, byte_valid}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {7'd0, byte_valid}, 8'd0);
    chk("arst_byte", byte_out, 8'h00);
    chk("arst_ovf", {7'd0, overflow}, 8'd0);
    chk("arst_dc", drop_count, 8'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    byte_ready = 1'b1;
    expq.push_back(8'h96);
    send_byte(8'h96);
    cyc(3);
    chk("post_rst_drained", 8'(expq.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
